// File: rtl/cylon_sequencer_if.sv
// Signal bundle between the cylon sequencer, its button/tick sources and the LED pins.
// The master side drives tick and button pulses; the slave side is the sequencer.
interface cylon_sequencer_if #(
  parameter int LED_COUNT       = 8,
  parameter int CLOCK_BIT_WIDTH = 30
);
  localparam int POS_W = $clog2(LED_COUNT);

  logic                       tick;
  logic                       speed_up;
  logic                       speed_down;
  logic                       pause_toggle;
  logic [CLOCK_BIT_WIDTH-1:0] clks_per_pulse;
  logic [3:0]                 speed_level;
  logic [LED_COUNT-1:0]       leds;
  logic [POS_W-1:0]           position;
  logic                       direction;
  logic                       paused;

  modport master (
    output tick, speed_up, speed_down, pause_toggle,
    input  clks_per_pulse, speed_level, leds, position, direction, paused
  );

  modport slave (
    input  tick, speed_up, speed_down, pause_toggle,
    output clks_per_pulse, speed_level, leds, position, direction, paused
  );
endinterface

// File: rtl/cylon_sequencer.sv
// Sweeps a single lit LED back and forth on each generator tick, with pause/resume
// and a saturating speed level that sets the generator period.
module cylon_sequencer #(
  parameter int                         LED_COUNT       = 8,
  parameter int                         CLOCK_BIT_WIDTH = 30,
  parameter logic [CLOCK_BIT_WIDTH-1:0] BASE_PERIOD     = 30'd100_000_000,
  parameter int                         SPEED_LEVELS    = 8,
  parameter int                         SPEED_RESET     = 3
) (
  input  logic               clk,
  input  logic               reset,
  cylon_sequencer_if.slave   bus
);
  localparam int                 POS_W    = $clog2(LED_COUNT);
  localparam logic [POS_W-1:0]   POS_MAX  = POS_W'(LED_COUNT - 1);
  localparam logic [POS_W-1:0]   POS_TURN = POS_W'(LED_COUNT - 2);
  localparam logic [3:0]         LVL_MAX  = 4'(SPEED_LEVELS - 1);
  localparam logic [3:0]         LVL_RST  = 4'(SPEED_RESET);

  typedef enum logic [1:0] {
    SWEEP_UP   = 2'd0,
    SWEEP_DOWN = 2'd1,
    PAUSED     = 2'd2
  } state_t;

  state_t                     state_q, state_nx;
  logic [POS_W-1:0]           pos_q, pos_nx;
  logic                       dir_q, dir_nx;
  logic                       resume_q, resume_nx;
  logic                       paused_q;
  logic [LED_COUNT-1:0]       leds_q;
  logic [3:0]                 lvl_q, lvl_nx;
  logic [CLOCK_BIT_WIDTH-1:0] period_q;

  function automatic logic [CLOCK_BIT_WIDTH-1:0] period_for(input logic [3:0] lvl);
    return BASE_PERIOD >> lvl;
  endfunction

  // Simultaneous up/down cancel; each direction saturates at its end.
  function automatic logic [3:0] level_step(input logic [3:0] lvl,
                                            input logic up, input logic down);
    logic [3:0] res;
    res = lvl;
    if (up && !down && lvl < LVL_MAX)
      res = lvl + 4'd1;
    else if (down && !up && lvl != 4'd0)
      res = lvl - 4'd1;
    return res;
  endfunction

  function automatic logic [LED_COUNT-1:0] one_hot(input logic [POS_W-1:0] pos);
    return LED_COUNT'(1) << pos;
  endfunction

  // pause_toggle takes priority over tick in every state.
  always_comb begin
    state_nx  = state_q;
    pos_nx    = pos_q;
    dir_nx    = dir_q;
    resume_nx = resume_q;
    case (state_q)
      SWEEP_UP: begin
        if (bus.pause_toggle) begin
          state_nx  = PAUSED;
          resume_nx = dir_q;
        end else if (bus.tick) begin
          if (pos_q < POS_MAX) begin
            pos_nx = pos_q + POS_W'(1);
          end else begin
            pos_nx   = POS_TURN;
            state_nx = SWEEP_DOWN;
            dir_nx   = 1'b0;
          end
        end
      end
      SWEEP_DOWN: begin
        if (bus.pause_toggle) begin
          state_nx  = PAUSED;
          resume_nx = dir_q;
        end else if (bus.tick) begin
          if (pos_q != '0) begin
            pos_nx = pos_q - POS_W'(1);
          end else begin
            pos_nx   = POS_W'(1);
            state_nx = SWEEP_UP;
            dir_nx   = 1'b1;
          end
        end
      end
      PAUSED: begin
        if (bus.pause_toggle)
          state_nx = resume_q ? SWEEP_UP : SWEEP_DOWN;
      end
      default: state_nx = SWEEP_UP;
    endcase
    lvl_nx = level_step(lvl_q, bus.speed_up, bus.speed_down);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= SWEEP_UP;
      pos_q    <= '0;
      dir_q    <= 1'b1;
      resume_q <= 1'b1;
      paused_q <= 1'b0;
      leds_q   <= LED_COUNT'(1);
      lvl_q    <= LVL_RST;
      period_q <= period_for(LVL_RST);
    end else begin
      state_q  <= state_nx;
      pos_q    <= pos_nx;
      dir_q    <= dir_nx;
      resume_q <= resume_nx;
      paused_q <= (state_nx == PAUSED);
      leds_q   <= one_hot(pos_nx);
      lvl_q    <= lvl_nx;
      period_q <= period_for(lvl_nx);
    end
  end

  assign bus.clks_per_pulse = period_q;
  assign bus.speed_level    = lvl_q;
  assign bus.leds           = leds_q;
  assign bus.position       = pos_q;
  assign bus.direction      = dir_q;
  assign bus.paused         = paused_q;
endmodule

// File: tb/tb_cylon_sequencer.sv
// Scoreboard bench for cylon_sequencer: a sweep-phase reference model predicts every cycle,
// a monitor compares, and a small pulse generator closes the loop for tick spacing.
module tb_cylon_sequencer;
  localparam int          N    = 4;
  localparam int          CW   = 30;
  localparam int          BASE = 64;
  localparam int          SL   = 4;
  localparam int          SR   = 1;

  typedef struct packed {
    logic [3:0]    leds;
    logic [1:0]    pos;
    logic          dir;
    logic          pz;
    logic [3:0]    lvl;
    logic [CW-1:0] per;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cylon_sequencer_if #(.LED_COUNT(N), .CLOCK_BIT_WIDTH(CW)) bus();

  cylon_sequencer #(
    .LED_COUNT(N), .CLOCK_BIT_WIDTH(CW), .BASE_PERIOD(30'(BASE)),
    .SPEED_LEVELS(SL), .SPEED_RESET(SR)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];

  // Reference model: k counts honoured ticks since reset; the lit position is a triangle wave of k.
  int k, lvl, gcnt;
  bit pz;

  function automatic int model_pos();
    int ph = k % (2*N - 2);
    return (ph < N) ? ph : (2*N - 2 - ph);
  endfunction

  function automatic bit model_dir();
    int ph = k % (2*N - 2);
    if (k == 0) return 1'b1;
    return (ph >= 1 && ph <= N - 1);
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e.leds = 4'(1 << model_pos());
    e.pos  = 2'(model_pos());
    e.dir  = model_dir();
    e.pz   = pz;
    e.lvl  = 4'(lvl);
    e.per  = CW'(BASE / (1 << lvl));
    return e;
  endfunction

  task automatic model_reset();
    k = 0; pz = 1'b0; lvl = SR; gcnt = 0;
  endtask

  task automatic check_snapshot(input string name, input exp_t e);
    exp_t got;
    got = {bus.leds, bus.position, bus.direction, bus.paused, bus.speed_level, bus.clks_per_pulse};
    vectors++;
    if (got !== e) begin
      miscompares++;
      $display("FAIL %s @%0t: got leds=%b pos=%0d dir=%b paused=%b lvl=%0d cpp=%0d, expected leds=%b pos=%0d dir=%b paused=%b lvl=%0d cpp=%0d",
               name, $time, got.leds, got.pos, got.dir, got.pz, got.lvl, got.per,
               e.leds, e.pos, e.dir, e.pz, e.lvl, e.per);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // One cycle of stimulus: drive just after the edge, then push the state expected after the next edge.
  task automatic step(input bit t, input bit u, input bit d, input bit p);
    @(posedge clk);
    #1;
    bus.tick = t; bus.speed_up = u; bus.speed_down = d; bus.pause_toggle = p;
    if (p) pz = !pz;
    else if (t && !pz) k++;
    if (u && !d && lvl < SL - 1) lvl++;
    else if (d && !u && lvl > 0) lvl--;
    q.push_back(model_exp());
  endtask

  // Pulse generator in the loop: ticks once every clks_per_pulse+1 clocks.
  task automatic gen_step(input bit u, input bit d, input bit p);
    bit t;
    t = (gcnt >= BASE / (1 << lvl));
    gcnt = t ? 0 : gcnt + 1;
    step(t, u, d, p);
  endtask

  task automatic drain();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: one expectation matures per clock edge.
  int   cyc = 0, last_chg = 0, gap = 0;
  logic [3:0] prev_leds = '0;
  initial begin
    int n;
    forever begin
      @(posedge clk);
      n = q.size();
      @(negedge clk);
      cyc++;
      if (bus.leds !== prev_leds) begin
        gap = cyc - last_chg;
        last_chg = cyc;
        prev_leds = bus.leds;
      end
      if (n > 0 && q.size() > 0 && !reset)
        check_snapshot("scoreboard", q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t rst_exp;
    rst_exp = '{leds: 4'b0001, pos: 2'd0, dir: 1'b1, pz: 1'b0, lvl: 4'd1, per: 30'd32};
    bus.tick = 1'b0; bus.speed_up = 1'b0; bus.speed_down = 1'b0; bus.pause_toggle = 1'b0;
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    check_snapshot("reset_initial", rst_exp);

    // Bounce: 8 ticks spaced by idle cycles, then two more to sit at 2 moving down.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Pause at position 2 moving down; ticks ignored; resume and tick.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Collisions: toggle beats tick when pausing and when resuming.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Speed saturation both ways, then both buttons together; works while paused too.
    repeat (4) begin step(1'b0, 1'b1, 1'b0, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0); end
    repeat (5) begin step(1'b0, 1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0); end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    drain();

    // Asynchronous reset mid-cycle after activity.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    drain();
    @(posedge clk);
    #3 reset = 1'b1;
    model_reset();
    #1 check_snapshot("reset_async_assert", rst_exp);
    #7 reset = 1'b0;
    #1 check_snapshot("reset_release", rst_exp);

    // Randomized traffic.
    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
    drain();

    // Closed loop with the pulse generator.
    gcnt = 0;
    if (pz) gen_step(1'b0, 1'b0, 1'b1);
    repeat (4) gen_step(1'b1, 1'b0, 1'b0);
    repeat (60) gen_step(1'b0, 1'b0, 1'b0);
    check_val("gap_level3", gap, 9);
    repeat (4) gen_step(1'b0, 1'b1, 1'b0);
    repeat (300) gen_step(1'b0, 1'b0, 1'b0);
    check_val("gap_level0", gap, 65);
    drain();
    check_val("scoreboard_drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
